// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the ID stage / CP0 / hazard unit and the IF-stage PC unit.
interface pc_fetch_unit_if;
  logic        stall_i;
  logic        branch_i;
  logic        is_branch_i;
  logic [15:0] imm16_i;
  logic        jump_i;
  logic [25:0] instr_index_i;
  logic        jr_i;
  logic [31:0] rs_val_i;
  logic [31:0] pc_id_i;
  logic        exc_req_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        bd_id_o;
  logic        adel_o;
  logic        flush_o;

  modport master (
    output stall_i, branch_i, is_branch_i, imm16_i, jump_i, instr_index_i,
           jr_i, rs_val_i, pc_id_i, exc_req_i, eret_i, epc_i,
    input  pc_o, pc4_o, bd_id_o, adel_o, flush_o
  );

  modport slave (
    input  stall_i, branch_i, is_branch_i, imm16_i, jump_i, instr_index_i,
           jr_i, rs_val_i, pc_id_i, exc_req_i, eret_i, epc_i,
    output pc_o, pc4_o, bd_id_o, adel_o, flush_o
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// IF-stage PC register and next-PC select; redirects land on pc_o one edge after ID presents them.
// Stall holds PC/delay-slot flag; exception and eret override stall.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] PC_MIN    = 32'h0000_3000,
  parameter logic [31:0] PC_MAX    = 32'h0000_4FFC
) (
  input  logic            clk,
  input  logic            reset,
  pc_fetch_unit_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [31:0] pc_id_plus4;
  logic [31:0] br_target;
  logic [31:0] jump_target;

  always_comb begin
    pc_id_plus4 = bus.pc_id_i + 32'd4;
    br_target   = pc_id_plus4 + {{14{bus.imm16_i[15]}}, bus.imm16_i, 2'b00};
    jump_target = {pc_id_plus4[31:28], bus.instr_index_i, 2'b00};
    pc_d        = pc_q;
    bd_d        = bd_q;
    if (bus.exc_req_i) begin
      pc_d = EXC_ENTRY;
      bd_d = 1'b0;
    end else if (bus.eret_i) begin
      pc_d = bus.epc_i;
      bd_d = 1'b0;
    end else if (!bus.stall_i) begin
      // Delay-slot flag follows the control instruction, taken or not.
      bd_d = bus.branch_i | bus.jump_i | bus.jr_i;
      if (bus.jr_i)
        pc_d = bus.rs_val_i;
      else if (bus.jump_i)
        pc_d = jump_target;
      else if (bus.branch_i && bus.is_branch_i)
        pc_d = br_target;
      else
        pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      bd_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      bd_q <= bd_d;
    end
  end

  assign bus.pc_o    = pc_q;
  assign bus.pc4_o   = pc_q + 32'd4;
  assign bus.bd_id_o = bd_q;
  assign bus.adel_o  = (pc_q[1:0] != 2'b00) | (pc_q < PC_MIN) | (pc_q > PC_MAX);
  assign bus.flush_o = bus.exc_req_i | bus.eret_i;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario-driven bench for pc_fetch_unit; expected fetch state is queued per edge and compared after it.
module tb_pc_fetch_unit;

  typedef struct {
    logic        exc;
    logic        eret;
    logic        stall;
    logic        jr;
    logic        jump;
    logic        branch;
    logic        taken;
    logic [15:0] imm16;
    logic [25:0] index;
    logic [31:0] rs;
    logic [31:0] pc_id;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic        adel;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } row_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  exp_t sb[$];

  pc_fetch_unit_if bus();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t br(input logic [31:0] pc_id, input logic [15:0] imm, input logic taken);
    stim_t s;
    s = idle();
    s.branch = 1'b1;
    s.taken  = taken;
    s.imm16  = imm;
    s.pc_id  = pc_id;
    return s;
  endfunction

  function automatic stim_t jmp(input logic [31:0] pc_id, input logic [25:0] idx);
    stim_t s;
    s = idle();
    s.jump  = 1'b1;
    s.index = idx;
    s.pc_id = pc_id;
    return s;
  endfunction

  function automatic stim_t jreg(input logic [31:0] rs);
    stim_t s;
    s = idle();
    s.jr = 1'b1;
    s.rs = rs;
    return s;
  endfunction

  function automatic exp_t ex(input logic [31:0] pc, input logic bd, input logic adel);
    exp_t e;
    e.pc = pc;
    e.bd = bd;
    e.adel = adel;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.exc_req_i     = s.exc;
    bus.eret_i        = s.eret;
    bus.stall_i       = s.stall;
    bus.jr_i          = s.jr;
    bus.jump_i        = s.jump;
    bus.branch_i      = s.branch;
    bus.is_branch_i   = s.taken;
    bus.imm16_i       = s.imm16;
    bus.instr_index_i = s.index;
    bus.rs_val_i      = s.rs;
    bus.pc_id_i       = s.pc_id;
    bus.epc_i         = s.epc;
  endtask

  task automatic test_reset();
    drive(idle());
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pc_o !== 32'h3000 || bus.bd_id_o !== 1'b0 || bus.adel_o !== 1'b0 || bus.pc4_o !== 32'h3004) begin
      errors++;
      $display("FAIL reset_hold: pc=%h bd=%b adel=%b pc4=%h required pc=3000 bd=0 adel=0 pc4=3004",
               bus.pc_o, bus.bd_id_o, bus.adel_o, bus.pc4_o);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (bus.pc_o !== 32'h3000 || bus.bd_id_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: pc=%h bd=%b required pc=3000 bd=0", bus.pc_o, bus.bd_id_o);
    end
  endtask

  task automatic test_sequential();
    row_t rows[$];
    exp_t e;
    rows.push_back('{idle(), ex(32'h3004, 1'b0, 1'b0)});
    rows.push_back('{idle(), ex(32'h3008, 1'b0, 1'b0)});
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel || bus.pc4_o !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL seq[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_branch();
    row_t rows[$];
    exp_t e;
    rows.push_back('{br(32'h3010, 16'hFFFC, 1'b1), ex(32'h3004, 1'b1, 1'b0)});
    rows.push_back('{br(32'h3010, 16'hFFFC, 1'b0), ex(32'h3008, 1'b1, 1'b0)});
    rows.push_back('{idle(),                       ex(32'h300C, 1'b0, 1'b0)});
    rows.push_back('{br(32'h3008, 16'h0010, 1'b1), ex(32'h304C, 1'b1, 1'b0)});
    rows.push_back('{idle(),                       ex(32'h3050, 1'b0, 1'b0)});
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel) begin
        errors++;
        $display("FAIL branch[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_jump();
    row_t rows[$];
    exp_t e;
    rows.push_back('{jmp(32'h3020, 26'h0001040),     ex(32'h0000_4100, 1'b1, 1'b0)});
    rows.push_back('{jreg(32'h3400),                 ex(32'h3400, 1'b1, 1'b0)});
    rows.push_back('{idle(),                         ex(32'h3404, 1'b0, 1'b0)});
    // Region bits come from pc_id+4, which here carries into bit 29.
    rows.push_back('{jmp(32'h1FFF_FFFC, 26'h0000010), ex(32'h2000_0040, 1'b1, 1'b1)});
    rows.push_back('{jreg(32'h3400),                 ex(32'h3400, 1'b1, 1'b0)});
    rows.push_back('{idle(),                         ex(32'h3404, 1'b0, 1'b0)});
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel) begin
        errors++;
        $display("FAIL jump[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_stall_exc();
    row_t rows[$];
    row_t rw;
    exp_t e;
    rows.push_back('{br(32'h3400, 16'h0004, 1'b1), ex(32'h3414, 1'b1, 1'b0)});
    rw = '{br(32'h3414, 16'h0020, 1'b1), ex(32'h3414, 1'b1, 1'b0)};
    rw.s.stall = 1'b1;
    rows.push_back(rw);
    rows.push_back(rw);
    rw.s.exc = 1'b1;
    rw.e = ex(32'h4180, 1'b0, 1'b0);
    rows.push_back(rw);
    rows.push_back('{idle(), ex(32'h4184, 1'b0, 1'b0)});
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      #1;
      checks++;
      if (bus.flush_o !== (rows[i].s.exc | rows[i].s.eret)) begin
        errors++;
        $display("FAIL stall_flush[%0d]: flush=%b required %b", i, bus.flush_o, rows[i].s.exc | rows[i].s.eret);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel) begin
        errors++;
        $display("FAIL stall_exc[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_eret();
    row_t rows[$];
    row_t rw;
    exp_t e;
    rw = '{jmp(32'h3000, 26'h0000000), ex(32'h3048, 1'b0, 1'b0)};
    rw.s.eret = 1'b1;
    rw.s.epc  = 32'h3048;
    rows.push_back(rw);
    rows.push_back('{idle(), ex(32'h304C, 1'b0, 1'b0)});
    rw = '{idle(), ex(32'h4180, 1'b0, 1'b0)};
    rw.s.exc  = 1'b1;
    rw.s.eret = 1'b1;
    rw.s.epc  = 32'h3048;
    rows.push_back(rw);
    rows.push_back('{idle(), ex(32'h4184, 1'b0, 1'b0)});
    rw = '{br(32'h3010, 16'hFFFC, 1'b1), ex(32'h4180, 1'b0, 1'b0)};
    rw.s.exc = 1'b1;
    rows.push_back(rw);
    rw = '{idle(), ex(32'h3100, 1'b0, 1'b0)};
    rw.s.eret  = 1'b1;
    rw.s.stall = 1'b1;
    rw.s.epc   = 32'h3100;
    rows.push_back(rw);
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      #1;
      checks++;
      if (bus.flush_o !== (rows[i].s.exc | rows[i].s.eret)) begin
        errors++;
        $display("FAIL eret_flush[%0d]: flush=%b required %b", i, bus.flush_o, rows[i].s.exc | rows[i].s.eret);
      end
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel) begin
        errors++;
        $display("FAIL eret[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_adel();
    row_t rows[$];
    exp_t e;
    rows.push_back('{jreg(32'h3002),      ex(32'h3002, 1'b1, 1'b1)});
    rows.push_back('{idle(),              ex(32'h3006, 1'b0, 1'b1)});
    rows.push_back('{jreg(32'h5000),      ex(32'h5000, 1'b1, 1'b1)});
    rows.push_back('{jreg(32'h4FFC),      ex(32'h4FFC, 1'b1, 1'b0)});
    rows.push_back('{idle(),              ex(32'h5000, 1'b0, 1'b1)});
    rows.push_back('{jreg(32'h2FFC),      ex(32'h2FFC, 1'b1, 1'b1)});
    rows.push_back('{jreg(32'h3000),      ex(32'h3000, 1'b1, 1'b0)});
    rows.push_back('{jreg(32'hFFFF_FFFC), ex(32'hFFFF_FFFC, 1'b1, 1'b1)});
    rows.push_back('{idle(),              ex(32'h0000_0000, 1'b0, 1'b1)});
    foreach (rows[i]) begin
      drive(rows[i].s);
      sb.push_back(rows[i].e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd || bus.adel_o !== e.adel || bus.pc4_o !== e.pc + 32'd4) begin
        errors++;
        $display("FAIL adel[%0d]: pc=%h bd=%b adel=%b required pc=%h bd=%b adel=%b",
                 i, bus.pc_o, bus.bd_id_o, bus.adel_o, e.pc, e.bd, e.adel);
      end
    end
  endtask

  task automatic test_async_reset();
    stim_t s;
    exp_t  e;
    drive(jreg(32'h3400));
    sb.push_back(ex(32'h3400, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd) begin
      errors++;
      $display("FAIL async_pre: pc=%h bd=%b required pc=%h bd=%b", bus.pc_o, bus.bd_id_o, e.pc, e.bd);
    end
    // Drop reset between edges with a stalled branch in ID.
    s = br(32'h3400, 16'h0004, 1'b1);
    s.stall = 1'b1;
    drive(s);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.pc_o !== 32'h3000 || bus.bd_id_o !== 1'b0 || bus.adel_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: pc=%h bd=%b adel=%b required pc=3000 bd=0 adel=0",
               bus.pc_o, bus.bd_id_o, bus.adel_o);
    end
    drive(idle());
    #1;
    reset = 1'b1;
    sb.push_back(ex(32'h3004, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.pc_o !== e.pc || bus.bd_id_o !== e.bd) begin
      errors++;
      $display("FAIL async_post: pc=%h bd=%b required pc=%h bd=%b", bus.pc_o, bus.bd_id_o, e.pc, e.bd);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall_exc();
    test_eret();
    test_adel();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and next-PC selector for the IF stage of the 5-stage MIPS pipeline with interrupts.
- Consumes the ID-stage branch decision from the branch comparator, plus decoded jump/jr controls from ID.
- Applies CP0 exception-entry and eret redirects, and hazard-unit stalls.
- Drives the fetch address, the delay-slot flag for the IF/ID register, and a fetch address-error flag for CP0.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_ENTRY, 32'h0000_4180: exception/interrupt handler entry address.
- PC_MIN, 32'h0000_3000: lowest legal fetch address.
- PC_MAX, 32'h0000_4FFC: highest legal fetch address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard unit: hold PC and delay-slot flag.
- branch_i  in  1  instruction in ID is a conditional branch (beq/bne/blez/bgtz/bltz/bgez).
- is_branch_i  in  1  comparator result: the branch in ID is taken.
- imm16_i  in  16  offset field of the instruction in ID.
- jump_i  in  1  instruction in ID is j or jal.
- instr_index_i  in  26  index field of the instruction in ID.
- jr_i  in  1  instruction in ID is jr or jalr.
- rs_val_i  in  32  forwarded rs value in ID (jr target).
- pc_id_i  in  32  PC of the instruction in ID.
- exc_req_i  in  1  CP0: take exception/interrupt now.
- eret_i  in  1  CP0: eret committing now.
- epc_i  in  32  CP0 EPC value.
- pc_o  out  32  current fetch address (registered).
- pc4_o  out  32  pc_o + 4.
- bd_id_o  out  1  registered; the instruction now in ID is a branch delay slot.
- adel_o  out  1  combinational fetch address error on pc_o.
- flush_o  out  1  combinational; exc_req_i | eret_i; IF/ID must be cleared.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-stall or mid-redirect): pc_o = RESET_PC, bd_id_o = 0.
- Reset release: first fetch at RESET_PC on the first rising edge after release.
- Next-PC priority, evaluated every rising edge while reset=1, highest first:
  1. exc_req_i: PC <= EXC_ENTRY; bd_id_o <= 0. Ignores stall_i.
  2. eret_i: PC <= epc_i; bd_id_o <= 0. Ignores stall_i. eret has no delay slot.
  3. stall_i: PC and bd_id_o hold.
  4. jr_i: PC <= rs_val_i.
  5. jump_i: PC <= {pc_id_i_plus4[31:28], instr_index_i, 2'b00}, where pc_id_i_plus4 = pc_id_i + 4.
  6. branch_i & is_branch_i: PC <= pc_id_i + 4 + (sign_extend(imm16_i) << 2).
  7. Otherwise: PC <= pc_o + 4.
- Arithmetic: all additions are 32-bit modulo 2^32; wrap-around is silent, and adel_o flags the result.
- Delay-slot flag: when neither exc_req_i nor eret_i is set and stall_i=0, bd_id_o <= branch_i | jump_i | jr_i. The flag is set regardless of whether the branch is taken.
- The instruction fetched while a control instruction sits in ID always executes; this unit never squashes it.
- Redirect latency: one cycle. The target appears on pc_o on the edge following the cycle in which ID presents the control instruction.
- adel_o = (pc_o[1:0] != 0) | (pc_o < PC_MIN) | (pc_o > PC_MAX), unsigned compare. The PC still advances normally; CP0 decides.
- flush_o is purely combinational from exc_req_i | eret_i; it does not depend on stall_i.
- Simultaneous events:
  - exc_req_i with eret_i: exception wins.
  - exc_req_i with a taken branch: exception wins; the branch target is discarded.
  - jr_i with jump_i or branch_i asserted together is illegal decode; the priority above still yields a deterministic result.

Test Plan:
- Reset and sequential fetch: hold reset=0 for 3 cycles, then release → pc_o=0x3000, bd_id_o=0, then 0x3004, 0x3008 on successive edges; adel_o=0.
- Taken branch with delay slot: pc_id_i=0x3010, branch_i=1, is_branch_i=1, imm16_i=0xFFFC → next pc_o=0x3004, bd_id_o=1. Repeat with is_branch_i=0 → pc_o=pc+4 and bd_id_o=1 still.
- jump and jr: pc_id_i=0x3020, jump_i=1, instr_index_i=0x0001040 → pc_o=0x0000_4100. Then jr_i=1, rs_val_i=0x3400 → pc_o=0x3400.
- Stall vs exception:
  - stall_i=1 for 2 cycles with a branch in ID → pc_o and bd_id_o frozen.
  - Assert exc_req_i during the stall → pc_o=0x4180, bd_id_o=0, flush_o=1 in that cycle.
- eret and conflict:
  - eret_i=1, epc_i=0x3048 → pc_o=0x3048, bd_id_o=0.
  - exc_req_i=1 and eret_i=1 together → pc_o=0x4180.
- Address error and async reset:
  - jr to rs_val_i=0x3002 → adel_o=1 next cycle.
  - jr to 0x5000 → adel_o=1.
  - Drop reset mid-cycle (between edges) → pc_o=0x3000 immediately, without waiting for clk.
